// File: rtl/bp_l15_req_decoder.sv
// BP mem-command to OpenPiton L1.5 request bridge; accept at N, l15 val from N+1 until ack, one request in flight.
// Backpressure: mem_cmd_ready_o stays low from accept until the matching L1.5 return; the request is held until ack.
module bp_l15_req_decoder #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p  = 64,
  parameter int cnt_width_p   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_o,
  input  logic                     mem_cmd_wr_i,
  input  logic [paddr_width_p-1:0] mem_cmd_addr_i,
  input  logic [1:0]               mem_cmd_size_i,
  input  logic [data_width_p-1:0]  mem_cmd_data_i,
  output logic                     transducer_l15_val,
  output logic [4:0]               transducer_l15_rqtype,
  output logic [paddr_width_p-1:0] transducer_l15_address,
  output logic [2:0]               transducer_l15_size,
  output logic [data_width_p-1:0]  transducer_l15_data,
  output logic                     transducer_l15_nc,
  input  logic                     l15_transducer_ack,
  input  logic                     l15_transducer_val,
  input  logic [3:0]               l15_transducer_returntype,
  output logic                     pending_o,
  output logic [cnt_width_p-1:0]   req_count_o,
  output logic                     err_o
);

  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e state;
  logic   wr_q;
  logic   ret_known;
  logic   ret_match;

  // Only LOAD_RET / ST_ACK belong to this bridge; any other return code is invisible here.
  assign ret_known = l15_transducer_val &&
                     (l15_transducer_returntype == LOAD_RET || l15_transducer_returntype == ST_ACK);
  assign ret_match = l15_transducer_val &&
                     (l15_transducer_returntype == (wr_q ? ST_ACK : LOAD_RET));

  assign mem_cmd_ready_o   = (state == S_IDLE) && reset_n_i;
  assign pending_o         = (state != S_IDLE);
  assign transducer_l15_nc = 1'b0;

  // Fill every byte lane by cycling through the low 2^size bytes of the store data.
  function automatic logic [data_width_p-1:0] replicate(input logic [1:0] size,
                                                        input logic [data_width_p-1:0] d);
    logic [data_width_p-1:0] r;
    int unsigned             nb;
    r  = '0;
    nb = 32'd1 << size;
    for (int unsigned i = 0; i < data_width_p / 8; i++) begin
      r[i*8 +: 8] = d[(i % nb)*8 +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state                  <= S_IDLE;
      wr_q                   <= 1'b0;
      transducer_l15_val     <= 1'b0;
      transducer_l15_rqtype  <= 5'b00000;
      transducer_l15_address <= '0;
      transducer_l15_size    <= 3'b000;
      transducer_l15_data    <= '0;
      req_count_o            <= '0;
      err_o                  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ret_known) err_o <= 1'b1;
          if (mem_cmd_v_i) begin
            state                  <= S_REQ;
            wr_q                   <= mem_cmd_wr_i;
            transducer_l15_val     <= 1'b1;
            transducer_l15_rqtype  <= {4'b0000, mem_cmd_wr_i};
            transducer_l15_address <= mem_cmd_addr_i;
            transducer_l15_size    <= {1'b0, mem_cmd_size_i} + 3'd1;
            transducer_l15_data    <= mem_cmd_wr_i ? replicate(mem_cmd_size_i, mem_cmd_data_i) : '0;
          end
        end
        S_REQ: begin
          if (l15_transducer_ack) begin
            transducer_l15_val <= 1'b0;
            if (ret_match) begin
              state       <= S_IDLE;
              req_count_o <= req_count_o + 1'b1;
            end else begin
              state <= S_WAIT;
              if (ret_known) err_o <= 1'b1;
            end
          end else if (ret_known) begin
            err_o <= 1'b1;
          end
        end
        S_WAIT: begin
          if (ret_match) begin
            state       <= S_IDLE;
            req_count_o <= req_count_o + 1'b1;
          end else if (ret_known) begin
            err_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_l15_req_decoder.sv
// Self-checking bench for bp_l15_req_decoder: directed scenarios plus randomized transactions
// compared against an arithmetic reference of the request formatting and transaction counting.
module tb_bp_l15_req_decoder;

  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] ST_ACK   = 4'b0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_v = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [39:0] cmd_addr = '0;
  logic [1:0]  cmd_size = '0;
  logic [63:0] cmd_data = '0;
  logic        l15_val;
  logic [4:0]  l15_rqtype;
  logic [39:0] l15_addr;
  logic [2:0]  l15_size;
  logic [63:0] l15_data;
  logic        l15_nc;
  logic        ack = 1'b0;
  logic        ret_v = 1'b0;
  logic [3:0]  ret_type = '0;
  logic        pending;
  logic [15:0] count;
  logic        err;

  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = '0;
  logic        exp_err = 1'b0;

  bp_l15_req_decoder #(.paddr_width_p(40), .data_width_p(64), .cnt_width_p(16)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .mem_cmd_v_i(cmd_v), .mem_cmd_ready_o(cmd_ready), .mem_cmd_wr_i(cmd_wr),
    .mem_cmd_addr_i(cmd_addr), .mem_cmd_size_i(cmd_size), .mem_cmd_data_i(cmd_data),
    .transducer_l15_val(l15_val), .transducer_l15_rqtype(l15_rqtype),
    .transducer_l15_address(l15_addr), .transducer_l15_size(l15_size),
    .transducer_l15_data(l15_data), .transducer_l15_nc(l15_nc),
    .l15_transducer_ack(ack), .l15_transducer_val(ret_v),
    .l15_transducer_returntype(ret_type),
    .pending_o(pending), .req_count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: unit = low (8<<size) bits, laid end to end across 64 bits.
  function automatic logic [63:0] model_data(input logic wr, input logic [1:0] size, input logic [63:0] d);
    logic [63:0] unit, r;
    int          nbits;
    if (!wr) return 64'd0;
    nbits = 8 << size;
    unit  = (nbits == 64) ? d : (d & ((64'd1 << nbits) - 64'd1));
    r = 64'd0;
    for (int k = 0; k < 64 / nbits; k++) r = r | (unit << (k * nbits));
    return r;
  endfunction

  // Stimulus helpers: all driving happens on the falling edge.
  task automatic do_cmd(input logic wr, input logic [39:0] a, input logic [1:0] s, input logic [63:0] d);
    cmd_v = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_size = s; cmd_data = d;
    @(negedge clk);
    cmd_v = 1'b0; cmd_wr = ~wr; cmd_addr = ~a; cmd_size = ~s; cmd_data = ~d;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic do_ret(input logic [3:0] t);
    ret_v = 1'b1; ret_type = t;
    @(negedge clk);
    ret_v = 1'b0; ret_type = 4'b1111;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++; if (l15_val !== 1'b0) begin bad++; $display("FAIL rst_val: got %b want 0", l15_val); end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", cmd_ready); end
    total++; if ({l15_rqtype, l15_addr, l15_size, l15_data, l15_nc} !== '0) begin bad++; $display("FAIL rst_fields: got nonzero request fields"); end
    total++; if ({pending, count, err} !== '0) begin bad++; $display("FAIL rst_status: got pend=%b cnt=%0d err=%b want 0", pending, count, err); end
    reset_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
  endtask

  task automatic test_load();
    do_cmd(1'b0, 40'h80_0000_1000, 2'd3, 64'hFFFF_0000_FFFF_0000);
    total++; if ({l15_val, l15_rqtype, l15_size} !== {1'b1, 5'b00000, 3'b100}) begin bad++; $display("FAIL load_req: got val=%b rq=%b sz=%b want 1/00000/100", l15_val, l15_rqtype, l15_size); end
    total++; if (l15_addr !== 40'h80_0000_1000) begin bad++; $display("FAIL load_addr: got %h want 8000001000", l15_addr); end
    total++; if (l15_data !== 64'd0) begin bad++; $display("FAIL load_data: got %h want 0", l15_data); end
    total++; if ({cmd_ready, pending, l15_nc} !== 3'b010) begin bad++; $display("FAIL load_busy: got rdy=%b pend=%b nc=%b want 0/1/0", cmd_ready, pending, l15_nc); end
    repeat (2) @(negedge clk);
    total++; if (l15_val !== 1'b1) begin bad++; $display("FAIL load_hold: got val=%b want 1", l15_val); end
    do_ack();
    total++; if ({l15_val, pending} !== 2'b01) begin bad++; $display("FAIL load_acked: got val=%b pend=%b want 0/1", l15_val, pending); end
    @(negedge clk);
    do_ret(LOAD_RET);
    exp_cnt++;
    total++; if ({pending, cmd_ready} !== 2'b01 || count !== exp_cnt) begin bad++; $display("FAIL load_done: got pend=%b rdy=%b cnt=%0d want 0/1/%0d", pending, cmd_ready, count, exp_cnt); end
  endtask

  task automatic test_stores();
    logic [1:0]  sz  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [63:0] din [4] = '{64'hFFFF_FFFF_FFFF_FFAB, 64'h7777_7777_7777_1234,
                             64'h5555_5555_DEAD_BEEF, 64'h0123_4567_89AB_CDEF};
    logic [63:0] want[4] = '{64'hABAB_ABAB_ABAB_ABAB, 64'h1234_1234_1234_1234,
                             64'hDEAD_BEEF_DEAD_BEEF, 64'h0123_4567_89AB_CDEF};
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b1, 40'h00_0000_2000 + 40'(i * 8), sz[i], din[i]);
      total++; if (l15_data !== want[i]) begin bad++; $display("FAIL store_data[%0d]: got %h want %h", i, l15_data, want[i]); end
      total++; if ({l15_val, l15_rqtype, l15_size} !== {1'b1, 5'b00001, 3'(i + 1)}) begin bad++; $display("FAIL store_req[%0d]: got val=%b rq=%b sz=%b", i, l15_val, l15_rqtype, l15_size); end
      do_ack();
      do_ret(ST_ACK);
      exp_cnt++;
      total++; if (count !== exp_cnt || pending !== 1'b0) begin bad++; $display("FAIL store_done[%0d]: got cnt=%0d pend=%b want %0d/0", i, count, pending, exp_cnt); end
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] a;
    logic [63:0] d;
    a = {$urandom, $urandom};
    d = {$urandom, $urandom};
    do_cmd(1'b1, a, 2'd1, d);
    for (int c = 0; c < 10; c++) begin
      total++;
      if ({l15_val, cmd_ready, l15_rqtype, l15_size} !== {2'b10, 5'b00001, 3'b010} ||
          l15_addr !== a || l15_data !== model_data(1'b1, 2'd1, d)) begin
        bad++; $display("FAIL bp_hold[%0d]: got val=%b rdy=%b addr=%h data=%h want 1/0/%h/%h",
                        c, l15_val, cmd_ready, l15_addr, l15_data, a, model_data(1'b1, 2'd1, d));
      end
      @(negedge clk);
    end
    ack = 1'b1; ret_v = 1'b1; ret_type = ST_ACK;
    @(negedge clk);
    ack = 1'b0; ret_v = 1'b0; ret_type = 4'b1111;
    exp_cnt++;
    total++; if ({pending, cmd_ready, l15_val} !== 3'b010 || count !== exp_cnt) begin bad++; $display("FAIL bp_same_cycle: got pend=%b rdy=%b val=%b cnt=%0d want 0/1/0/%0d", pending, cmd_ready, l15_val, count, exp_cnt); end
  endtask

  task automatic test_random();
    logic        wr;
    logic [1:0]  s;
    logic [39:0] a;
    logic [63:0] d;
    int          errs;
    errs = 0;
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      s  = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      do_cmd(wr, a, s, d);
      total++;
      if ({l15_val, l15_rqtype, l15_size} !== {1'b1, 4'b0000, wr, 3'(s) + 3'd1} ||
          l15_addr !== a || l15_data !== model_data(wr, s, d)) begin
        bad++; errs++;
        $display("FAIL rand_req[%0d]: got rq=%b sz=%b addr=%h data=%h want %b/%0d/%h/%h",
                 n, l15_rqtype, l15_size, l15_addr, l15_data, wr, s + 1, a, model_data(wr, s, d));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        ack = 1'b1; ret_v = 1'b1; ret_type = wr ? ST_ACK : LOAD_RET;
        @(negedge clk);
        ack = 1'b0; ret_v = 1'b0; ret_type = 4'b1111;
      end else begin
        do_ack();
        if ($urandom_range(0, 1) == 1) do_ret(4'b0010);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_ret(wr ? ST_ACK : LOAD_RET);
      end
      exp_cnt++;
      total++;
      if ({pending, cmd_ready, err} !== {2'b01, exp_err} || count !== exp_cnt) begin
        bad++; $display("FAIL rand_done[%0d]: got pend=%b rdy=%b err=%b cnt=%0d want 0/1/%b/%0d",
                        n, pending, cmd_ready, err, count, exp_err, exp_cnt);
      end
    end
  endtask

  task automatic test_errors();
    do_ret(4'b0010);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_unknown_code: got %b want 0", err); end
    do_ret(LOAD_RET);
    exp_err = 1'b1;
    total++; if ({err, pending, cmd_ready} !== 3'b101) begin bad++; $display("FAIL err_idle_ret: got err=%b pend=%b rdy=%b want 1/0/1", err, pending, cmd_ready); end
    repeat (3) @(negedge clk);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    do_cmd(1'b0, 40'h12_3456_7000, 2'd3, 64'd0);
    do_ack();
    do_ret(ST_ACK);
    total++; if ({err, pending} !== 2'b11 || count !== exp_cnt) begin bad++; $display("FAIL err_wrong_type: got err=%b pend=%b cnt=%0d want 1/1/%0d", err, pending, count, exp_cnt); end
    do_ret(LOAD_RET);
    exp_cnt++;
    total++; if ({pending, cmd_ready} !== 2'b01 || count !== exp_cnt) begin bad++; $display("FAIL err_recover: got pend=%b rdy=%b cnt=%0d want 0/1/%0d", pending, cmd_ready, count, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    do_cmd(1'b1, 40'h00_0000_4000, 2'd2, 64'h1111_2222_3333_4444);
    total++; if (l15_val !== 1'b1) begin bad++; $display("FAIL midrst_pre: got val=%b want 1", l15_val); end
    reset_n = 1'b0;
    exp_cnt = '0;
    exp_err = 1'b0;
    #2;
    total++; if ({l15_val, pending, cmd_ready, err} !== 4'b0000 || count !== exp_cnt) begin bad++; $display("FAIL midrst_async: got val=%b pend=%b rdy=%b err=%b cnt=%0d want all 0", l15_val, pending, cmd_ready, err, count); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
    @(negedge clk);
    do_cmd(1'b0, 40'h00_0000_5000, 2'd0, 64'hFF);
    total++; if ({l15_val, l15_rqtype, l15_size} !== {1'b1, 5'b00000, 3'b001} || l15_data !== 64'd0) begin bad++; $display("FAIL midrst_load: got val=%b rq=%b sz=%b data=%h", l15_val, l15_rqtype, l15_size, l15_data); end
    do_ack();
    do_ret(LOAD_RET);
    exp_cnt++;
    total++; if (count !== exp_cnt || pending !== 1'b0) begin bad++; $display("FAIL midrst_done: got cnt=%0d pend=%b want %0d/0", count, pending, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stores();
    test_backpressure();
    test_random();
    test_errors();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
